// File: rtl/alu_mc_pkg.sv
// Shared op codes, FSM states and helpers for the multi-cycle ALU.
// Used by the top, the iterative mul/div unit and the control decoder.
package alu_mc_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_MUL  = 4'b0011,
        OP_DIV  = 4'b0100,
        OP_REM  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLLI = 4'b1001,
        OP_SLL  = 4'b1010,
        OP_PASS = 4'b1011,
        OP_NOR  = 4'b1100,
        OP_NAND = 4'b1101,
        OP_SRAI = 4'b1110,
        OP_SRL  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } alu_state_e;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand magnitudes.
// One step per run cycle; sign handling lives in the caller.
module alu_iter_muldiv
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             mul_i,
    input  logic [WIDTH-1:0] mag1_i,
    input  logic [WIDTH-1:0] mag2_i,
    input  logic             run_i,
    input  logic             upd_i,
    output logic             last_o,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] opa_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mul_q, mul_d;
    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   diff;

    // For MUL acc is the running product, opa the multiplicand, opb the multiplier.
    // For DIV acc is the partial remainder, opa shifts the dividend out and the quotient in.
    always_comb begin
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
        mul_d = mul_q;
        rs    = {acc_q, opa_q[WIDTH-1]};
        diff  = rs - {1'b0, opb_q};
        if (load_i) begin
            acc_d = '0;
            opa_d = mag1_i;
            opb_d = mag2_i;
            cnt_d = '0;
            mul_d = mul_i;
        end else if (run_i) begin
            cnt_d = cnt_q + CW'(1);
            if (upd_i) begin
                if (mul_q) begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + opa_q;
                    end
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                    opb_d = {1'b0, opb_q[WIDTH-1:1]};
                end else if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rs[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            mul_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
            mul_q <= mul_d;
        end
    end

    assign last_o = run_i && (cnt_q == CW'(WIDTH - 1));
    assign acc_o  = acc_q;
    assign opa_o  = opa_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops plus iterative signed MUL/DIV/REM
// behind a start/busy/done handshake with registered result and flags.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             div_by_zero_o
);

    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [SHW-1:0] sh);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_SLTU: r[0] = (a < b);
            OP_SLT:  r[0] = (sa < sb);
            OP_SLLI: r = b << sh;
            OP_SLL:  r = b << a[SHW-1:0];
            OP_PASS: r = b;
            OP_SRAI: r = sb >>> sh;
            OP_SRL:  r = b >> a[SHW-1:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    alu_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             neg1_q, neg1_d;
    logic             neg2_q, neg2_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             dbzo_q, dbzo_d;

    logic             load, run, last;
    logic [WIDTH-1:0] mag1, mag2, acc, opa;

    assign mag1 = sign_fix(src1_i, src1_i[WIDTH-1]);
    assign mag2 = sign_fix(src2_i, src2_i[WIDTH-1]);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .mul_i  (ctrl_i == OP_MUL),
        .mag1_i (mag1),
        .mag2_i (mag2),
        .run_i  (run),
        .upd_i  (!dbz_q),
        .last_o (last),
        .acc_o  (acc),
        .opa_o  (opa)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        dbz_d    = dbz_q;
        src1_d   = src1_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        dbzo_d   = dbzo_q;
        load     = 1'b0;
        run      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (is_multi(ctrl_i)) begin
                        load    = 1'b1;
                        op_d    = ctrl_i;
                        neg1_d  = src1_i[WIDTH-1];
                        neg2_d  = src2_i[WIDTH-1];
                        dbz_d   = (ctrl_i != OP_MUL) && (src2_i == '0);
                        src1_d  = src1_i;
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        result_d = alu_single(ctrl_i, src1_i, src2_i, shamt_i);
                        done_d   = 1'b1;
                        dbzo_d   = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                // The counter still runs on divide-by-zero so latency stays fixed.
                run = 1'b1;
                if (last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                case (op_q)
                    OP_MUL:  result_d = sign_fix(acc, neg1_q ^ neg2_q);
                    OP_DIV:  result_d = dbz_q ? '1 : sign_fix(opa, neg1_q ^ neg2_q);
                    OP_REM:  result_d = dbz_q ? src1_q : sign_fix(acc, neg1_q);
                    default: result_d = '0;
                endcase
                done_d  = 1'b1;
                busy_d  = 1'b0;
                dbzo_d  = dbz_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= 4'b0000;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            dbz_q    <= 1'b0;
            src1_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dbzo_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            dbz_q    <= dbz_d;
            src1_q   <= src1_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dbzo_q   <= dbzo_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign zero_o        = zero_q;
    assign div_by_zero_o = dbzo_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0;
    logic [3:0]  ctrl32 = 4'h0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [4:0]  sh32 = '0;
    logic        busy32, done32, zero32, dbz32;
    logic [31:0] res32;

    logic        start8 = 1'b0;
    logic [3:0]  ctrl8 = 4'h0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  sh8 = '0;
    logic        busy8, done8, zero8, dbz8;
    logic [7:0]  res8;

    int vectors = 0;
    int miscompares = 0;
    int bbad = 0;
    int lat;
    int seen;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32), .ctrl_i(ctrl32),
        .src1_i(a32), .src2_i(b32), .shamt_i(sh32), .busy_o(busy32),
        .done_o(done32), .result_o(res32), .zero_o(zero32), .div_by_zero_o(dbz32)
    );

    alu_mc #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .ctrl_i(ctrl8),
        .src1_i(a8), .src2_i(b8), .shamt_i(sh8), .busy_o(busy8),
        .done_o(done8), .result_o(res8), .zero_o(zero8), .div_by_zero_o(dbz8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns with the bench sitting in the done cycle.
    task automatic run32(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int poke, output int l);
        l = -1;
        start32 = 1'b1; ctrl32 = c; a32 = a; b32 = b; sh32 = sh;
        @(posedge clk); #1;
        start32 = 1'b0; ctrl32 = 4'b0010; a32 = 32'h1111_1111; b32 = 32'h2222_2222;
        for (int n = 1; n <= 60; n++) begin
            if (done32) begin
                l = n;
                if (busy32) bbad++;
                break;
            end
            if (!busy32) bbad++;
            if (n == poke) begin
                start32 = 1'b1; ctrl32 = 4'b0010;
            end
            @(posedge clk); #1;
            start32 = 1'b0;
        end
    endtask

    task automatic run8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                        output int l);
        l = -1;
        start8 = 1'b1; ctrl8 = c; a8 = a; b8 = b; sh8 = 3'd0;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        for (int n = 1; n <= 30; n++) begin
            if (done8) begin
                l = n;
                if (busy8) bbad++;
                break;
            end
            if (!busy8) bbad++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_result", res32, 0);
        chk("rst_zero", zero32, 1);
        chk("rst_dbz", dbz32, 0);
        chk("rst8_result", res8, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run32(4'b0010, 32'd7, 32'd5, 5'd0, 0, lat);
        chk("add_lat", lat, 1);
        chk("add_res", res32, 32'h0000_000C);
        chk("add_zero", zero32, 0);
        run32(4'b0110, 32'd9, 32'd9, 5'd0, 0, lat);
        chk("sub_res", res32, 0);
        chk("sub_zero", zero32, 1);
        run32(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 0, lat);
        chk("and_res", res32, 32'h0000_F000);
        run32(4'b1100, 32'h0, 32'h0, 5'd0, 0, lat);
        chk("nor_res", res32, 32'hFFFF_FFFF);
        run32(4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, lat);
        chk("slt_res", res32, 32'd1);
        run32(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, lat);
        chk("sltu_res", res32, 32'd0);
        run32(4'b1010, 32'h21, 32'd1, 5'd0, 0, lat);
        chk("sll_reg_res", res32, 32'd2);
        run32(4'b1001, 32'h0, 32'd3, 5'd4, 0, lat);
        chk("slli_res", res32, 32'h30);

        bbad = 0;
        run32(4'b0011, 32'hFFFF_FFFD, 32'd7, 5'd0, 0, lat);
        chk("mul_lat", lat, 34);
        chk("mul_res", res32, 32'hFFFF_FFEB);
        chk("mul_busy", bbad, 0);
        run32(4'b0010, 32'd1, 32'd2, 5'd0, 0, lat);
        chk("b2b_add_lat", lat, 1);
        chk("b2b_add_res", res32, 32'd3);

        run32(4'b0100, 32'hFFFF_FFF9, 32'd2, 5'd0, 0, lat);
        chk("div_lat", lat, 34);
        chk("div_res", res32, 32'hFFFF_FFFD);
        chk("div_dbz", dbz32, 0);
        run32(4'b0101, 32'hFFFF_FFF9, 32'd2, 5'd0, 0, lat);
        chk("rem_res", res32, 32'hFFFF_FFFF);
        run32(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, lat);
        chk("div_min_res", res32, 32'h8000_0000);
        chk("div_min_dbz", dbz32, 0);
        run32(4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, lat);
        chk("rem_min_res", res32, 32'h0);
        chk("rem_min_zero", zero32, 1);
        run32(4'b0100, 32'd100, 32'd7, 5'd0, 0, lat);
        chk("div_100_7", res32, 32'd14);
        run32(4'b0101, 32'd100, 32'd7, 5'd0, 0, lat);
        chk("rem_100_7", res32, 32'd2);
        run32(4'b0100, 32'd7, 32'hFFFF_FFFE, 5'd0, 0, lat);
        chk("div_7_m2", res32, 32'hFFFF_FFFD);
        run32(4'b0101, 32'd7, 32'hFFFF_FFFE, 5'd0, 0, lat);
        chk("rem_7_m2", res32, 32'd1);

        run32(4'b0100, 32'd5, 32'd0, 5'd0, 0, lat);
        chk("div0_lat", lat, 34);
        chk("div0_res", res32, 32'hFFFF_FFFF);
        chk("div0_flag", dbz32, 1);
        run32(4'b0101, 32'd5, 32'd0, 5'd0, 0, lat);
        chk("rem0_res", res32, 32'd5);
        chk("rem0_flag", dbz32, 1);
        run32(4'b1011, 32'd0, 32'h55, 5'd0, 0, lat);
        chk("pass_res", res32, 32'h55);
        chk("pass_flag_clr", dbz32, 0);

        run32(4'b1110, 32'h0, 32'h8000_0000, 5'd4, 0, lat);
        chk("sra_res", res32, 32'hF800_0000);
        run32(4'b1111, 32'h23, 32'h8000_0000, 5'd0, 0, lat);
        chk("srl_res", res32, 32'h1000_0000);

        bbad = 0;
        run32(4'b0011, 32'd6, 32'hFFFF_FFFB, 5'd0, 5, lat);
        chk("mul_poke_lat", lat, 34);
        chk("mul_poke_res", res32, 32'hFFFF_FFE2);
        chk("mul_poke_busy", bbad, 0);

        bbad = 0;
        run8(4'b0011, 8'hFD, 8'd7, lat);
        chk("mul8_lat", lat, 10);
        chk("mul8_res", res8, 8'hEB);
        chk("mul8_busy", bbad, 0);
        run8(4'b0100, 8'hF9, 8'd2, lat);
        chk("div8_res", res8, 8'hFD);
        run8(4'b0101, 8'hF9, 8'd2, lat);
        chk("rem8_res", res8, 8'hFF);
        run8(4'b0100, 8'h80, 8'hFF, lat);
        chk("div8_min_res", res8, 8'h80);
        chk("div8_min_dbz", dbz8, 0);
        run8(4'b0100, 8'd5, 8'd0, lat);
        chk("div8_0_lat", lat, 10);
        chk("div8_0_res", res8, 8'hFF);
        chk("div8_0_flag", dbz8, 1);
        run8(4'b0101, 8'd5, 8'd0, lat);
        chk("rem8_0_res", res8, 8'h05);
        chk("rem8_0_flag", dbz8, 1);

        // Abort a divide partway through with an asynchronous reset.
        start32 = 1'b1; ctrl32 = 4'b0100; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy32, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy32, 0);
        chk("abort_result", res32, 0);
        chk("abort_zero", zero32, 1);
        chk("abort_done", done32, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32) seen++;
        end
        chk("abort_no_done", seen, 0);
        run32(4'b0010, 32'd1, 32'd1, 5'd0, 0, lat);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_res", res32, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
